pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline. It detects RAW hazards between the ID-stage sources and the EXE/MEM destinations, and drives the `hazard` input of the ID stage. It issues branch flushes and owns the multi-cycle SRAM handshake for the MEM stage, freezing every pipeline register while the memory is busy. It also keeps saturating stall and flush performance counters.

Parameters:
REG_NUM_BITS, 4, register-index width
CNT_WIDTH, 16, width of each performance counter
TIMEOUT, 64, max MEM_WAIT cycles before forced release

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
forward_en  in  1  1 = forwarding unit present; only load-use hazards stall
id_first_src  in  REG_NUM_BITS  Rn index of the instruction in ID
id_second_src  in  REG_NUM_BITS  Rm/Rd index of the instruction in ID
id_two_src  in  1  ID instruction reads the second source
exe_dest  in  REG_NUM_BITS  destination register in EXE
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
mem_dest  in  REG_NUM_BITS  destination register in MEM
mem_wb_en  in  1  MEM instruction writes back
mem_req  in  1  MEM instruction is a load or store (mem_r_en | mem_w_en)
sram_ready  in  1  SRAM completion, valid only in MEM_WAIT
branch_taken  in  1  EXE-stage b flag
hazard  out  1  to ID stage; bubbles ID/EXE and holds IF, IF/ID
freeze  out  1  holds all pipeline registers and the PC
flush  out  1  clears IF/ID and ID/EXE
sram_start  out  1  one-cycle request pulse to SRAM
timeout_err  out  1  sticky; set on SRAM timeout
stall_cnt  out  CNT_WIDTH  cycles with hazard or freeze high
flush_cnt  out  CNT_WIDTH  number of flush pulses

Behaviour:
- States: RUN, MEM_WAIT. Reset: state=RUN, wait counter=0. All outputs are 0 except the combinational `hazard`, which follows the inputs with `flush`=0.
- Raw hazard:
  - src1_hit(X) = X_wb_en & (id_first_src==X_dest).
  - src2_hit(X) = X_wb_en & id_two_src & (id_second_src==X_dest).
  - If forward_en=0: raw = src1_hit(exe) | src2_hit(exe) | src1_hit(mem) | src2_hit(mem).
  - If forward_en=1: raw = exe_mem_r_en & (src1_hit(exe) | src2_hit(exe)).
- Output equations:
  - hazard = raw & ~flush & ~freeze.
  - flush = branch_taken & ~freeze.
  - A branch held during a freeze flushes in the first unfrozen cycle.
- RUN:
  - If mem_req=1: freeze=1, sram_start=1 for this cycle only, next state MEM_WAIT, wait counter cleared.
  - Otherwise freeze=0.
- MEM_WAIT:
  - freeze = ~sram_ready.
  - sram_ready=1: next state RUN. MEM/WB captures the data this cycle.
  - The next mem_req is the following instruction and starts a new access.
  - sram_start=0 in MEM_WAIT.
  - Wait counter increments each cycle sram_ready=0.
  - When the counter reaches TIMEOUT-1 without ready: freeze=0 that cycle, timeout_err<=1 (cleared only by reset), next state RUN.
- sram_ready seen in RUN is ignored.
- Counters:
  - stall_cnt increments on every cycle with hazard|freeze.
  - flush_cnt increments on every cycle with flush.
  - Both saturate at all-ones.
- Reset mid-operation (including during MEM_WAIT): back to RUN, counters and timeout_err cleared, no sram_start issued that cycle.
- A branch and a hazard in the same cycle: flush=1, hazard=0.
- Register index 15 (PC) is compared like any other register.

Test Plan:
- forward_en=0, exe_wb_en=1, exe_dest=3, id_first_src=3 -> hazard=1, stall_cnt +1. Same setup with exe_wb_en=0 -> hazard=0.
- forward_en=0, mem_wb_en=1, mem_dest=5, id_second_src=5, id_two_src=0 -> hazard=0. Set id_two_src=1 -> hazard=1.
- forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=2, id_first_src=2 -> hazard=1. Same with exe_mem_r_en=0 -> hazard=0.
- mem_req=1 at cycle 0, sram_ready=1 at cycle 4 -> sram_start pulses only in cycle 0, freeze=1 in cycles 0–3 and 0 in cycle 4, state RUN in cycle 5, stall_cnt=4.
- branch_taken=1 during MEM_WAIT, ready on the 3rd wait cycle -> flush=0 while frozen, flush=1 in the ready cycle, flush_cnt=1. branch_taken with raw hazard in RUN -> flush=1, hazard=0.
- TIMEOUT=8, mem_req=1, sram_ready held 0 -> freeze drops after 8 cycles and timeout_err=1. Then rst=0 for one cycle -> timeout_err=0, counters=0, state RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage ARM pipeline.
//   * Detects RAW hazards between the ID-stage sources and the EXE/MEM
//     destinations and raises `hazard` toward the ID stage.
//   * Issues branch flushes (IF/ID and ID/EXE clear) on a taken EXE branch.
//   * Owns the multi-cycle SRAM handshake for the MEM stage: pulses
//     `sram_start`, then holds `freeze` until `sram_ready` or a timeout.
//   * Keeps saturating stall and flush performance counters.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   forward_en          forwarding unit present; only load-use hazards stall
//   id_first_src        Rn index of the ID instruction
//   id_second_src       Rm/Rd index of the ID instruction
//   id_two_src          ID instruction reads the second source
//   exe_dest/_wb_en     EXE destination register / write-back enable
//   exe_mem_r_en        EXE instruction is a load
//   mem_dest/_wb_en     MEM destination register / write-back enable
//   mem_req             MEM instruction accesses memory
//   sram_ready          SRAM completion (only meaningful while waiting)
//   branch_taken        EXE-stage taken branch
//   hazard              bubble ID/EXE, hold IF and IF/ID
//   freeze              hold every pipeline register and the PC
//   flush               clear IF/ID and ID/EXE
//   sram_start          one-cycle access request to the SRAM
//   timeout_err         sticky SRAM-timeout flag, cleared only by reset
//   stall_cnt           cycles with hazard or freeze high (saturating)
//   flush_cnt           flush pulses (saturating)
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_NUM_BITS = 4,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    forward_en,
  input  logic [REG_NUM_BITS-1:0] id_first_src,
  input  logic [REG_NUM_BITS-1:0] id_second_src,
  input  logic                    id_two_src,
  input  logic [REG_NUM_BITS-1:0] exe_dest,
  input  logic                    exe_wb_en,
  input  logic                    exe_mem_r_en,
  input  logic [REG_NUM_BITS-1:0] mem_dest,
  input  logic                    mem_wb_en,
  input  logic                    mem_req,
  input  logic                    sram_ready,
  input  logic                    branch_taken,
  output logic                    hazard,
  output logic                    freeze,
  output logic                    flush,
  output logic                    sram_start,
  output logic                    timeout_err,
  output logic [CNT_WIDTH-1:0]    stall_cnt,
  output logic [CNT_WIDTH-1:0]    flush_cnt
);

  localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } state_e;

  state_e                 state_q, state_d;
  logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

  logic in_reset;
  logic src1_hit_exe, src2_hit_exe, src1_hit_mem, src2_hit_mem;
  logic raw;
  logic mem_freeze;
  logic mem_start;
  logic timeout_hit;
  logic freeze_w, flush_w, hazard_w, start_w;

  // Reset is synchronous, so the state register may still hold StMemWait
  // during the reset cycle; gate the sequencer outputs so nothing leaks out.
  assign in_reset = ~rst;

  // --------------------------------------------------------------------------
  // RAW hazard detection
  // --------------------------------------------------------------------------
  assign src1_hit_exe = exe_wb_en & (id_first_src == exe_dest);
  assign src2_hit_exe = exe_wb_en & id_two_src & (id_second_src == exe_dest);
  assign src1_hit_mem = mem_wb_en & (id_first_src == mem_dest);
  assign src2_hit_mem = mem_wb_en & id_two_src & (id_second_src == mem_dest);

  always_comb begin
    raw = 1'b0;
    if (forward_en) begin
      // With forwarding only a load in EXE cannot supply its result in time.
      raw = exe_mem_r_en & (src1_hit_exe | src2_hit_exe);
    end else begin
      raw = src1_hit_exe | src2_hit_exe | src1_hit_mem | src2_hit_mem;
    end
  end

  // --------------------------------------------------------------------------
  // SRAM handshake FSM: next state and freeze/start decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_freeze  = 1'b0;
    mem_start   = 1'b0;
    timeout_hit = 1'b0;

    unique case (state_q)
      StRun: begin
        // sram_ready is ignored here; a stale ready must not release anything.
        if (mem_req) begin
          mem_freeze = 1'b1;
          mem_start  = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (sram_ready) begin
          // MEM/WB captures the data this cycle, so the pipeline moves.
          state_d = StRun;
        end else if (wait_cnt_q == WaitLast) begin
          // Give up on the SRAM: release the pipeline and flag the error.
          timeout_hit = 1'b1;
          state_d     = StRun;
        end else begin
          mem_freeze = 1'b1;
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pipeline control outputs
  // --------------------------------------------------------------------------
  assign freeze_w = mem_freeze & ~in_reset;
  assign start_w  = mem_start & ~in_reset;
  // A branch held through a freeze flushes in the first unfrozen cycle
  // because the frozen EXE stage keeps presenting branch_taken.
  assign flush_w  = branch_taken & ~freeze_w & ~in_reset;
  // A flush kills the ID instruction anyway, so no bubble is needed.
  assign hazard_w = raw & ~flush_w & ~freeze_w;

  assign hazard     = hazard_w;
  assign freeze     = freeze_w;
  assign flush      = flush_w;
  assign sram_start = start_w;

  // --------------------------------------------------------------------------
  // Error flag and saturating performance counters
  // --------------------------------------------------------------------------
  always_comb begin
    timeout_err_d = timeout_err_q | timeout_hit;

    stall_cnt_d = stall_cnt_q;
    if ((hazard_w | freeze_w) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    flush_cnt_d = flush_cnt_q;
    if (flush_w && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign timeout_err = timeout_err_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Scoreboard bench: every driven cycle the reference model pushes the
// expected outputs into a queue; at the falling edge the entry is popped and
// compared against the DUT. Directed checks against fixed constants cover the
// scenario list, followed by a constrained-random phase.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RegBits = 4;
  localparam int unsigned CntW    = 5;
  localparam int unsigned Tmo     = 8;
  localparam int          CntMax  = (1 << CntW) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               forward_en = 1'b0;
  logic [RegBits-1:0] id_first_src = '0;
  logic [RegBits-1:0] id_second_src = '0;
  logic               id_two_src = 1'b0;
  logic [RegBits-1:0] exe_dest = '0;
  logic               exe_wb_en = 1'b0;
  logic               exe_mem_r_en = 1'b0;
  logic [RegBits-1:0] mem_dest = '0;
  logic               mem_wb_en = 1'b0;
  logic               mem_req = 1'b0;
  logic               sram_ready = 1'b0;
  logic               branch_taken = 1'b0;
  logic               hazard, freeze, flush, sram_start, timeout_err;
  logic [CntW-1:0]    stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(
    .REG_NUM_BITS (RegBits),
    .CNT_WIDTH    (CntW),
    .TIMEOUT      (Tmo)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .forward_en    (forward_en),
    .id_first_src  (id_first_src),
    .id_second_src (id_second_src),
    .id_two_src    (id_two_src),
    .exe_dest      (exe_dest),
    .exe_wb_en     (exe_wb_en),
    .exe_mem_r_en  (exe_mem_r_en),
    .mem_dest      (mem_dest),
    .mem_wb_en     (mem_wb_en),
    .mem_req       (mem_req),
    .sram_ready    (sram_ready),
    .branch_taken  (branch_taken),
    .hazard        (hazard),
    .freeze        (freeze),
    .flush         (flush),
    .sram_start    (sram_start),
    .timeout_err   (timeout_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hz;
    logic frz;
    logic fl;
    logic st;
    logic err;
    int   stall;
    int   fcnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (values after reset).
  bit m_wait  = 1'b0;
  int m_wcnt  = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;
  int m_fcnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compute this cycle's expected outputs, queue them, then advance the model.
  task automatic model_push();
    bit   s1e, s2e, s1m, s2m, raw, frz, st, fl, hz, tmo;
    exp_t e;
    s1e = exe_wb_en && (id_first_src == exe_dest);
    s2e = exe_wb_en && id_two_src && (id_second_src == exe_dest);
    s1m = mem_wb_en && (id_first_src == mem_dest);
    s2m = mem_wb_en && id_two_src && (id_second_src == mem_dest);
    raw = forward_en ? (exe_mem_r_en && (s1e || s2e)) : (s1e || s2e || s1m || s2m);
    frz = 1'b0;
    st  = 1'b0;
    tmo = 1'b0;
    if (rst) begin
      if (!m_wait) begin
        frz = mem_req;
        st  = mem_req;
      end else if (!sram_ready) begin
        if (m_wcnt == int'(Tmo) - 1) tmo = 1'b1;
        else frz = 1'b1;
      end
    end
    fl = rst && branch_taken && !frz;
    hz = raw && !fl && !frz;

    e.hz = hz; e.frz = frz; e.fl = fl; e.st = st;
    e.err = m_err; e.stall = m_stall; e.fcnt = m_fcnt;
    sb_q.push_back(e);

    if (!rst) begin
      m_wait = 1'b0; m_wcnt = 0; m_err = 1'b0; m_stall = 0; m_fcnt = 0;
    end else begin
      if (!m_wait) begin
        if (mem_req) begin
          m_wait = 1'b1;
          m_wcnt = 0;
        end
      end else if (sram_ready || tmo) begin
        m_wait = 1'b0;
      end else begin
        m_wcnt++;
      end
      if (tmo) m_err = 1'b1;
      if ((hz || frz) && m_stall < CntMax) m_stall++;
      if (fl && m_fcnt < CntMax) m_fcnt++;
    end
  endtask

  // One clock: queue expectation, compare at negedge, advance past posedge.
  task automatic step();
    exp_t e;
    model_push();
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_hazard", 32'(hazard), 32'(e.hz));
      check_eq("sb_freeze", 32'(freeze), 32'(e.frz));
      check_eq("sb_flush", 32'(flush), 32'(e.fl));
      check_eq("sb_sram_start", 32'(sram_start), 32'(e.st));
      check_eq("sb_timeout_err", 32'(timeout_err), 32'(e.err));
      check_eq("sb_stall_cnt", 32'(stall_cnt), 32'(e.stall));
      check_eq("sb_flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    forward_en = 0; id_first_src = 0; id_second_src = 0; id_two_src = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
    mem_req = 0; sram_ready = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Registers are unknown before the first edge; take it unchecked.
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check_eq("rst_freeze", 32'(freeze), 32'd0);

    // EXE RAW without forwarding.
    exe_wb_en = 1; exe_dest = 3; id_first_src = 3;
    #1 check_eq("exe_src1_hazard", 32'(hazard), 32'd1);
    step();
    check_eq("exe_src1_stall_cnt", 32'(stall_cnt), 32'd1);
    exe_wb_en = 0;
    #1 check_eq("exe_no_wb_hazard", 32'(hazard), 32'd0);
    step();

    // MEM RAW on the second source.
    clear_inputs();
    mem_wb_en = 1; mem_dest = 5; id_second_src = 5; id_first_src = 0; id_two_src = 0;
    #1 check_eq("mem_src2_unused", 32'(hazard), 32'd0);
    step();
    id_two_src = 1;
    #1 check_eq("mem_src2_hazard", 32'(hazard), 32'd1);
    step();

    // Forwarding: load-use only.
    clear_inputs();
    forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 2; id_first_src = 2;
    #1 check_eq("fwd_load_use", 32'(hazard), 32'd1);
    step();
    exe_mem_r_en = 0;
    #1 check_eq("fwd_alu_no_stall", 32'(hazard), 32'd0);
    step();

    // PC register index.
    clear_inputs();
    exe_wb_en = 1; exe_dest = 15; id_first_src = 15;
    #1 check_eq("r15_hazard", 32'(hazard), 32'd1);
    step();

    // SRAM access, ready on the 4th cycle after the request.
    do_reset();
    mem_req = 1;
    #1 check_eq("mem_c0_start", 32'(sram_start), 32'd1);
    check_eq("mem_c0_freeze", 32'(freeze), 32'd1);
    step();
    for (int i = 1; i <= 3; i++) begin
      check_eq("mem_wait_start", 32'(sram_start), 32'd0);
      check_eq("mem_wait_freeze", 32'(freeze), 32'd1);
      step();
    end
    sram_ready = 1;
    #1 check_eq("mem_ready_freeze", 32'(freeze), 32'd0);
    step();
    mem_req = 0; sram_ready = 0;
    #1 check_eq("mem_c5_freeze", 32'(freeze), 32'd0);
    check_eq("mem_c5_start", 32'(sram_start), 32'd0);
    check_eq("mem_stall_cnt", 32'(stall_cnt), 32'd4);
    sram_ready = 1;
    #1 check_eq("ready_in_run_ignored", 32'(freeze), 32'd0);
    step();
    sram_ready = 0;

    // Branch held across a freeze.
    do_reset();
    mem_req = 1;
    step();
    branch_taken = 1;
    for (int i = 1; i <= 2; i++) begin
      check_eq("br_frozen_flush", 32'(flush), 32'd0);
      step();
    end
    sram_ready = 1;
    #1 check_eq("br_ready_flush", 32'(flush), 32'd1);
    step();
    clear_inputs();
    #1 check_eq("br_flush_cnt", 32'(flush_cnt), 32'd1);
    branch_taken = 1; exe_wb_en = 1; exe_dest = 3; id_first_src = 3;
    #1 check_eq("br_haz_flush", 32'(flush), 32'd1);
    check_eq("br_haz_hazard", 32'(hazard), 32'd0);
    step();

    // Timeout with ready never arriving.
    do_reset();
    mem_req = 1;
    step();
    mem_req = 0;
    for (int i = 1; i < int'(Tmo); i++) begin
      check_eq("tmo_freeze_hold", 32'(freeze), 32'd1);
      step();
    end
    check_eq("tmo_freeze_drop", 32'(freeze), 32'd0);
    step();
    check_eq("tmo_err_set", 32'(timeout_err), 32'd1);
    check_eq("tmo_stall_cnt", 32'(stall_cnt), 32'd8);
    step();
    check_eq("tmo_err_sticky", 32'(timeout_err), 32'd1);
    do_reset();
    check_eq("tmo_rst_err", 32'(timeout_err), 32'd0);
    check_eq("tmo_rst_stall", 32'(stall_cnt), 32'd0);
    check_eq("tmo_rst_flush", 32'(flush_cnt), 32'd0);
    mem_req = 1;
    #1 check_eq("tmo_rst_run_start", 32'(sram_start), 32'd1);
    step();
    step();
    rst = 0;
    #1 check_eq("rst_in_wait_freeze", 32'(freeze), 32'd0);
    check_eq("rst_in_wait_start", 32'(sram_start), 32'd0);
    step();
    rst = 1;
    mem_req = 0;
    step();

    // Counter saturation.
    do_reset();
    exe_wb_en = 1; exe_dest = 1; id_first_src = 1;
    for (int i = 0; i < 40; i++) step();
    check_eq("stall_sat", 32'(stall_cnt), 32'(CntMax));
    clear_inputs();
    branch_taken = 1;
    for (int i = 0; i < 40; i++) step();
    check_eq("flush_sat", 32'(flush_cnt), 32'(CntMax));

    // Constrained random against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      forward_en    = 1'($urandom_range(0, 1));
      id_first_src  = 4'($urandom_range(0, 3));
      id_second_src = 4'($urandom_range(0, 3));
      id_two_src    = 1'($urandom_range(0, 1));
      exe_dest      = 4'($urandom_range(0, 3));
      exe_wb_en     = 1'($urandom_range(0, 1));
      exe_mem_r_en  = 1'($urandom_range(0, 1));
      mem_dest      = 4'($urandom_range(0, 3));
      mem_wb_en     = 1'($urandom_range(0, 1));
      mem_req       = ($urandom_range(0, 3) == 0);
      sram_ready    = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      rst           = ($urandom_range(0, 59) != 0);
      step();
    end
    rst = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
